mem_port_arbiter: RTL and testbench

Shares the single 16-bit data memory port between the fetch stage (16-bit instruction reads) and the execute/memory stage (32-bit loads/stores). Each 32-bit data access is split into two halfword beats, low at the address and high at address+2. Data requests have priority, and a starvation counter guarantees fetch progress. The block sits between the pipeline stages and the memory macro and owns all memory-port sequencing.

---
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one 16-bit memory port between 16-bit instruction
//               fetches and 32-bit data loads/stores. A data word is split
//               into a low and a high halfword beat. Data has priority, and a
//               starvation counter forces a fetch after STARVE_LIMIT
//               consecutive data grants with fetch waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // fetch stage
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [15:0] if_rdata_o,
  // execute / memory stage
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  // memory macro
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i,
  input  logic        mem_rdy_i,
  // status
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DLO   = 2'd2,
    S_DHI   = 2'd3
  } state_t;

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  state_t      r_state;
  logic [3:0]  r_starve_cnt;
  logic [15:0] r_lo_q;
  logic        r_lo_cap;
  logic        r_if_rvalid;
  logic        r_d_rvalid;

  logic        w_if_gnt;
  logic        w_d_gnt;
  logic        w_lo_done;
  logic [3:0]  w_starve_nxt;
  logic [31:0] w_d_hi_addr;
  state_t      w_arb_state;
  logic        w_unused;

  // Halfword addresses ignore bit 0 of the requester addresses.
  assign w_unused    = ^{if_addr_i[0], d_addr_i[0]};

  // High beat address: +2 on the halfword-aligned address, wrapping at 2^32.
  assign w_d_hi_addr = {d_addr_i[31:1] + 31'd1, 1'b0};

  // Beat completions; grants are issued in the completing cycle.
  assign w_if_gnt    = (r_state == S_FETCH) && mem_rdy_i;
  assign w_d_gnt     = (r_state == S_DHI) && mem_rdy_i;
  assign w_lo_done   = (r_state == S_DLO) && mem_rdy_i;

  // Next starvation count; arbitration looks at the updated value so the
  // data grant that reaches the limit hands the following slot to fetch.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!if_req_i || w_if_gnt) begin
      w_starve_nxt = 4'd0;
    end else if (w_d_gnt && (r_starve_cnt < c_starve_limit)) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end
  end

  // Arbitration between fetch and data; data wins unless fetch is starved.
  always_comb begin
    w_arb_state = S_IDLE;
    if (d_req_i && if_req_i) begin
      w_arb_state = (w_starve_nxt == c_starve_limit) ? S_FETCH : S_DLO;
    end else if (d_req_i) begin
      w_arb_state = S_DLO;
    end else if (if_req_i) begin
      w_arb_state = S_FETCH;
    end
  end

  // Port sequencer: holds on wait states, re-arbitrates when an access ends.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= 4'd0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      case (r_state)
        S_IDLE:  r_state <= w_arb_state;
        S_FETCH: if (mem_rdy_i) r_state <= w_arb_state;
        S_DLO:   if (mem_rdy_i) r_state <= S_DHI;
        S_DHI:   if (mem_rdy_i) r_state <= w_arb_state;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read-return tracking: low halfword capture and rvalid pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lo_cap    <= 1'b0;
      r_lo_q      <= 16'd0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
    end else begin
      r_lo_cap    <= w_lo_done && !d_we_i;
      if (r_lo_cap) begin
        r_lo_q <= mem_rdata_i;
      end
      r_if_rvalid <= w_if_gnt;
      r_d_rvalid  <= w_d_gnt && !d_we_i;
    end
  end

  // Memory port drive; everything is zero while idle.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 16'd0;
    case (r_state)
      S_FETCH: begin
        mem_en_o   = 1'b1;
        mem_addr_o = {if_addr_i[31:1], 1'b0};
      end
      S_DLO: begin
        mem_en_o    = 1'b1;
        mem_we_o    = d_we_i;
        mem_addr_o  = {d_addr_i[31:1], 1'b0};
        mem_wdata_o = d_wdata_i[15:0];
      end
      S_DHI: begin
        mem_en_o    = 1'b1;
        mem_we_o    = d_we_i;
        mem_addr_o  = w_d_hi_addr;
        mem_wdata_o = d_wdata_i[31:16];
      end
      default: begin
        mem_en_o = 1'b0;
      end
    endcase
  end

  assign if_gnt_o    = w_if_gnt;
  assign d_gnt_o     = w_d_gnt;
  assign if_rvalid_o = r_if_rvalid;
  assign d_rvalid_o  = r_d_rvalid;
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = {mem_rdata_i, r_lo_q};
  assign busy_o      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: directed scenarios
//               plus randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int SL = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_req_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i;
  logic [15:0] if_rdata_o;
  logic        d_req_i, d_we_i, d_gnt_o, d_rvalid_o;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic        mem_en_o, mem_we_o, mem_rdy_i, busy_o;
  logic [31:0] mem_addr_o;
  logic [15:0] mem_wdata_o, mem_rdata_i;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.STARVE_LIMIT(SL)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_rdy_i(mem_rdy_i), .busy_o(busy_o)
  );

  // Memory contents seen by the random phase (bit 0 of the address ignored).
  function automatic logic [15:0] mem_val(input logic [31:0] a);
    return a[16:1] ^ a[31:16] ^ 16'h3C5A;
  endfunction

  // ---------------- reference model ----------------
  // owner: 0 none, 1 fetch, 2 data; half: which data halfword is in flight.
  int          m_owner, m_half, m_starve, m_s_nx;
  logic        m_done, m_fg, m_dg, m_ifrv, m_drv;
  logic [15:0] m_if_exp, m_lo_exp;
  logic [31:0] m_d_exp;

  always_comb begin
    m_done = (m_owner != 0) && mem_rdy_i;
    m_fg   = m_done && (m_owner == 1);
    m_dg   = m_done && (m_owner == 2) && (m_half == 1);
    m_s_nx = m_starve;
    if (!if_req_i || m_fg) m_s_nx = 0;
    else if (m_dg)         m_s_nx = (m_starve + 1 > SL) ? SL : m_starve + 1;
  end

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_owner <= 0; m_half <= 0; m_starve <= 0;
      m_ifrv <= 1'b0; m_drv <= 1'b0;
      m_if_exp <= '0; m_lo_exp <= '0; m_d_exp <= '0;
    end else begin
      m_starve <= m_s_nx;
      m_ifrv   <= m_fg;
      m_drv    <= m_dg && !d_we_i;
      if (m_fg) m_if_exp <= mem_val(if_addr_i);
      if (m_done && m_owner == 2 && m_half == 0) m_lo_exp <= mem_val(d_addr_i);
      if (m_dg) m_d_exp <= {mem_val(d_addr_i + 32'd2), m_lo_exp};
      if (m_owner == 2 && m_half == 0) begin
        if (mem_rdy_i) m_half <= 1;
      end else if (m_owner == 0 || m_done) begin
        m_half <= 0;
        if (d_req_i && (!if_req_i || m_s_nx < SL)) m_owner <= 2;
        else if (if_req_i)                         m_owner <= 1;
        else                                       m_owner <= 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk_i); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      mem_rdy_i = 1'b1;
      @(negedge clk_i);
      if (if_gnt_o) if_req_i = 1'b0;
      if (d_gnt_o)  d_req_i  = 1'b0;
      if (!busy_o && !if_req_i && !d_req_i) break;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    if_req_i = 0; if_addr_i = '0; d_req_i = 0; d_we_i = 0; d_addr_i = '0;
    d_wdata_i = '0; mem_rdy_i = 0; mem_rdata_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_total++;
    if ({if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_en_o, mem_we_o, busy_o} !== 7'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0000000",
        {if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_en_o, mem_we_o, busy_o});
    end
    n_total++;
    if (mem_addr_o !== 32'd0 || mem_wdata_o !== 16'd0) begin
      n_bad++; $display("FAIL reset_bus: got addr %h wdata %h want 0", mem_addr_o, mem_wdata_o);
    end
    n_total++;
    if (dut.r_starve_cnt !== 4'd0 || dut.r_lo_q !== 16'd0) begin
      n_bad++; $display("FAIL reset_regs: got cnt %0d lo %h want 0", dut.r_starve_cnt, dut.r_lo_q);
    end
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_fetch_only();
    next_cycle();                       // cycle 0
    if_req_i = 1; if_addr_i = 32'h100; mem_rdy_i = 1;
    next_cycle();                       // cycle 1
    @(negedge clk_i);
    n_total++;
    if (mem_en_o !== 1 || mem_addr_o !== 32'h100 || if_gnt_o !== 1 || mem_we_o !== 0) begin
      n_bad++; $display("FAIL fetch_beat: got en %b addr %h gnt %b we %b want 1 100 1 0",
        mem_en_o, mem_addr_o, if_gnt_o, mem_we_o);
    end
    if_req_i = 0;
    next_cycle();                       // cycle 2
    mem_rdata_i = 16'hBEEF;
    @(negedge clk_i);
    n_total++;
    if (if_rvalid_o !== 1 || if_rdata_o !== 16'hBEEF || if_gnt_o !== 0 || busy_o !== 0) begin
      n_bad++; $display("FAIL fetch_rdata: got rv %b data %h gnt %b busy %b want 1 beef 0 0",
        if_rvalid_o, if_rdata_o, if_gnt_o, busy_o);
    end
  endtask

  task automatic test_load_wait();
    logic [31:0] exp_a [1:3];
    logic        exp_g [1:3];
    exp_a[1] = 32'h2000; exp_a[2] = 32'h2000; exp_a[3] = 32'h2002;
    exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 1;
    next_cycle();                       // cycle 0
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h2000; mem_rdy_i = 1; mem_rdata_i = 16'h0;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      mem_rdy_i = (c != 1);
      if (c == 3) mem_rdata_i = 16'h5678;
      @(negedge clk_i);
      n_total++;
      if (mem_addr_o !== exp_a[c] || d_gnt_o !== exp_g[c] || mem_en_o !== 1) begin
        n_bad++; $display("FAIL load_beat%0d: got addr %h gnt %b en %b want %h %b 1",
          c, mem_addr_o, d_gnt_o, mem_en_o, exp_a[c], exp_g[c]);
      end
      if (d_gnt_o) d_req_i = 0;
    end
    next_cycle();                       // cycle 4
    mem_rdata_i = 16'h1234;
    @(negedge clk_i);
    n_total++;
    if (d_rvalid_o !== 1 || d_rdata_o !== 32'h12345678) begin
      n_bad++; $display("FAIL load_rdata: got rv %b data %h want 1 12345678", d_rvalid_o, d_rdata_o);
    end
  endtask

  task automatic test_store_wrap();
    next_cycle();
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'hFFFF_FFFE; d_wdata_i = 32'hAABBCCDD; mem_rdy_i = 1;
    next_cycle();
    @(negedge clk_i);
    n_total++;
    if (mem_addr_o !== 32'hFFFF_FFFE || mem_wdata_o !== 16'hCCDD || mem_we_o !== 1 || d_gnt_o !== 0) begin
      n_bad++; $display("FAIL store_lo: got %h %h we %b gnt %b want fffffffe ccdd 1 0",
        mem_addr_o, mem_wdata_o, mem_we_o, d_gnt_o);
    end
    next_cycle();
    @(negedge clk_i);
    n_total++;
    if (mem_addr_o !== 32'h0 || mem_wdata_o !== 16'hAABB || mem_we_o !== 1 || d_gnt_o !== 1) begin
      n_bad++; $display("FAIL store_hi: got %h %h we %b gnt %b want 00000000 aabb 1 1",
        mem_addr_o, mem_wdata_o, mem_we_o, d_gnt_o);
    end
    d_req_i = 0;
    next_cycle();
    @(negedge clk_i);
    n_total++;
    if (d_rvalid_o !== 0) begin
      n_bad++; $display("FAIL store_norv: got rv %b want 0", d_rvalid_o);
    end
    d_we_i = 0;
  endtask

  task automatic test_starvation();
    int          dg_cnt = 0;
    logic [31:0] ea;
    logic        eg_d, eg_i;
    next_cycle();                       // cycle 0
    if_req_i = 1; if_addr_i = 32'h300; d_req_i = 1; d_we_i = 0; d_addr_i = 32'h400; mem_rdy_i = 1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      @(negedge clk_i);
      eg_i = (c == 9);
      eg_d = (c <= 8) && (c % 2 == 0);
      ea   = eg_i ? 32'h300 : (eg_d ? 32'h402 : 32'h400);
      if (d_gnt_o) dg_cnt++;
      n_total++;
      if (mem_addr_o !== ea || d_gnt_o !== eg_d || if_gnt_o !== eg_i) begin
        n_bad++; $display("FAIL starve_c%0d: got addr %h dg %b ig %b want %h %b %b",
          c, mem_addr_o, d_gnt_o, if_gnt_o, ea, eg_d, eg_i);
      end
      if (c == 9) begin
        n_total++;
        if (dg_cnt != SL) begin
          n_bad++; $display("FAIL starve_count: got %0d data grants want %0d", dg_cnt, SL);
        end
      end
    end
    n_total++;
    if (dut.r_starve_cnt !== 4'd0) begin
      n_bad++; $display("FAIL starve_clear: got %0d want 0", dut.r_starve_cnt);
    end
    drain();
  endtask

  task automatic test_simultaneous();
    next_cycle();
    if_req_i = 1; if_addr_i = 32'h700; d_req_i = 1; d_we_i = 0; d_addr_i = 32'h800; mem_rdy_i = 1;
    next_cycle();
    @(negedge clk_i);
    n_total++;
    if (mem_addr_o !== 32'h800 || if_gnt_o !== 0) begin
      n_bad++; $display("FAIL simul_dlo: got addr %h ig %b want 800 0", mem_addr_o, if_gnt_o);
    end
    next_cycle();
    @(negedge clk_i);
    if (d_gnt_o) d_req_i = 0;
    next_cycle();
    @(negedge clk_i);
    n_total++;
    if (mem_addr_o !== 32'h700 || if_gnt_o !== 1) begin
      n_bad++; $display("FAIL simul_fetch: got addr %h ig %b want 700 1", mem_addr_o, if_gnt_o);
    end
    drain();
  endtask

  task automatic test_reset_mid_dhi();
    next_cycle();
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h500; mem_rdy_i = 1;
    next_cycle();                       // DLO
    next_cycle();                       // DHI, held by wait state
    mem_rdy_i = 0;
    @(negedge clk_i);
    n_total++;
    if (mem_addr_o !== 32'h502 || mem_en_o !== 1) begin
      n_bad++; $display("FAIL rst_pre: got addr %h en %b want 502 1", mem_addr_o, mem_en_o);
    end
    #1 rst_ni = 0;
    #1;
    n_total++;
    if ({mem_en_o, busy_o, d_gnt_o, mem_we_o} !== 4'b0 || mem_addr_o !== 32'd0) begin
      n_bad++; $display("FAIL rst_async: got en %b busy %b gnt %b addr %h want 0",
        mem_en_o, busy_o, d_gnt_o, mem_addr_o);
    end
    next_cycle();
    mem_rdy_i = 1;
    @(negedge clk_i);
    n_total++;
    if (d_gnt_o !== 0 || d_rvalid_o !== 0) begin
      n_bad++; $display("FAIL rst_nogrant: got gnt %b rv %b want 0 0", d_gnt_o, d_rvalid_o);
    end
    next_cycle();
    rst_ni = 1;
    next_cycle();
    @(negedge clk_i);
    n_total++;
    if (mem_addr_o !== 32'h500 || mem_en_o !== 1 || d_gnt_o !== 0) begin
      n_bad++; $display("FAIL rst_restart: got addr %h en %b gnt %b want 500 1 0",
        mem_addr_o, mem_en_o, d_gnt_o);
    end
    drain();
  endtask

  task automatic test_random();
    logic        rd_flag = 0;
    logic [15:0] rd_val  = '0;
    logic [6:0]  e_ctl;
    logic [31:0] e_addr;
    logic [15:0] e_wd;
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      mem_rdy_i   = ($urandom_range(0, 3) != 0);
      mem_rdata_i = rd_flag ? rd_val : 16'($urandom);
      rd_flag     = 0;
      if (!if_req_i && $urandom_range(0, 2) != 0) begin
        if_req_i = 1; if_addr_i = $urandom;
      end
      if (!d_req_i && $urandom_range(0, 2) == 0) begin
        d_req_i = 1; d_we_i = 1'($urandom); d_addr_i = $urandom; d_wdata_i = $urandom;
      end
      @(negedge clk_i);
      e_addr = 32'd0; e_wd = 16'd0;
      if (m_owner == 1) e_addr = if_addr_i & ~32'd1;
      if (m_owner == 2) begin
        e_addr = ((m_half == 1) ? d_addr_i + 32'd2 : d_addr_i) & ~32'd1;
        e_wd   = (m_half == 1) ? d_wdata_i[31:16] : d_wdata_i[15:0];
      end
      e_ctl = {m_owner != 0, (m_owner == 2) && d_we_i, m_fg, m_dg, m_ifrv, m_drv, m_owner != 0};
      n_total++;
      if ({mem_en_o, mem_we_o, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, busy_o} !== e_ctl) begin
        n_bad++; $display("FAIL rand_ctl@%0d: got %b want %b", i,
          {mem_en_o, mem_we_o, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, busy_o}, e_ctl);
      end
      n_total++;
      if (mem_addr_o !== e_addr || mem_wdata_o !== e_wd) begin
        n_bad++; $display("FAIL rand_bus@%0d: got %h/%h want %h/%h", i, mem_addr_o, mem_wdata_o, e_addr, e_wd);
      end
      if (m_ifrv) begin
        n_total++;
        if (if_rdata_o !== m_if_exp) begin
          n_bad++; $display("FAIL rand_ifdata@%0d: got %h want %h", i, if_rdata_o, m_if_exp);
        end
      end
      if (m_drv) begin
        n_total++;
        if (d_rdata_o !== m_d_exp) begin
          n_bad++; $display("FAIL rand_ddata@%0d: got %h want %h", i, d_rdata_o, m_d_exp);
        end
      end
      if (mem_en_o && mem_rdy_i && !mem_we_o) begin
        rd_flag = 1; rd_val = mem_val(mem_addr_o);
      end
      if (if_gnt_o) if_req_i = 0;
      if (d_gnt_o)  d_req_i  = 0;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_load_wait();
    test_store_wrap();
    test_starvation();
    test_simultaneous();
    test_reset_mid_dhi();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
